// File: rtl/coco_ioctl_upload.sv
// ---------------------------------------------------------------------------
// coco_ioctl_upload
//
// Serves HPS upload (save) requests by reading core memory and handing the
// bytes back on ioctl_din. This is the read-side twin of the ioctl download
// path. Each HPS read strobe becomes one request to the memory arbiter. The HPS
// is held off with ioctl_wait until the arbiter answers or a timeout expires.
//
// Ports
//   clk_sys        system clock, everything on its rising edge
//   reset          synchronous, active-high reset
//   ioctl_upload   HPS upload session active
//   ioctl_index    file/slot index of the current session
//   ioctl_rd       one-cycle read strobe from the HPS
//   ioctl_addr     byte address of the read
//   ioctl_din      byte returned to the HPS (holds between reads)
//   ioctl_wait     high while a fetch is outstanding
//   mem_req        read request to the arbiter, held until mem_ack
//   mem_addr       memory address, stable while mem_req is high
//   mem_ack        one-cycle acknowledge, mem_dout valid in the same cycle
//   mem_dout       read data from memory
//   upload_active  a session for INDEX is in progress (core may halt its CPU)
//   err_timeout    sticky flag: a fetch timed out during this session
// ---------------------------------------------------------------------------
module coco_ioctl_upload #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned SIZE    = 32'h8000,
    parameter int unsigned BASE    = 32'h0000,
    parameter logic [7:0]  INDEX   = 8'd1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout,
    output logic              upload_active,
    output logic              err_timeout
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    // One extra bit on the size so that SIZE == 2**ADDR_W still compares
    // correctly against the full address range.
    localparam logic [ADDR_W:0]   SIZE_EXT = (ADDR_W + 1)'(SIZE);
    localparam logic [ADDR_W-1:0] BASE_W   = ADDR_W'(BASE);
    localparam logic [7:0]        LAST     = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_count;
    logic       sel;
    logic       out_of_range;

    // The block answers only while the HPS runs an upload session for our
    // slot. Reads past the exposed image size never touch memory.
    always_comb begin
        sel          = ioctl_upload && (ioctl_index == INDEX);
        out_of_range = ({1'b0, ioctl_addr} >= SIZE_EXT);
    end

    // Session tracking plus the fetch state machine. upload_active doubles as
    // the previous value of sel, so a rising session edge is sel && !upload_active.
    // That edge clears the sticky timeout flag. In FETCH a dropped session
    // beats an acknowledge, and an acknowledge beats the timeout. Read strobes
    // that arrive while a fetch is outstanding are ignored.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state         <= IDLE;
            wait_count    <= 8'd0;
            ioctl_din     <= 8'hFF;
            ioctl_wait    <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            upload_active <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            upload_active <= sel;
            if (sel && !upload_active) begin
                err_timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ioctl_rd && sel) begin
                        if (out_of_range) begin
                            ioctl_din <= 8'hFF;
                        end else begin
                            mem_addr   <= ioctl_addr + BASE_W;
                            mem_req    <= 1'b1;
                            ioctl_wait <= 1'b1;
                            wait_count <= 8'd0;
                            state      <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    if (!sel) begin
                        mem_req    <= 1'b0;
                        ioctl_wait <= 1'b0;
                        state      <= IDLE;
                    end else if (mem_ack) begin
                        ioctl_din  <= mem_dout;
                        mem_req    <= 1'b0;
                        ioctl_wait <= 1'b0;
                        state      <= IDLE;
                    end else if (wait_count == LAST) begin
                        ioctl_din   <= 8'hFF;
                        mem_req     <= 1'b0;
                        ioctl_wait  <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coco_ioctl_upload.sv
// ---------------------------------------------------------------------------
// tb_coco_ioctl_upload
//
// Exercises coco_ioctl_upload with a relocated base address, so that memory
// addresses wrap. A bench-side memory image answers mem_req. Each HPS read
// is described by:
//   - the FETCH cycle on which the arbiter acknowledges (0 = never)
//   - the cycle on which the session is dropped (0 = never)
//   - whether the session carries the wrong index
// The expected stall length, returned byte and error flag are worked out per
// transaction from those three values.
// ---------------------------------------------------------------------------
module tb_coco_ioctl_upload;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned SIZE    = 32'h8000;
    localparam int unsigned BASE    = 32'hF000;
    localparam int unsigned TIMEOUT = 255;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_dout;
    logic        upload_active;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_img [65536];
    logic [7:0] exp_din;
    logic       exp_err;

    always #5 clk_sys = ~clk_sys;

    coco_ioctl_upload #(
        .ADDR_W  (ADDR_W),
        .SIZE    (SIZE),
        .BASE    (BASE),
        .INDEX   (8'd1),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_upload  (ioctl_upload),
        .ioctl_index   (ioctl_index),
        .ioctl_rd      (ioctl_rd),
        .ioctl_addr    (ioctl_addr),
        .ioctl_din     (ioctl_din),
        .ioctl_wait    (ioctl_wait),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_dout      (mem_dout),
        .upload_active (upload_active),
        .err_timeout   (err_timeout)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
        end
    endtask

    // All outputs must sit at their reset values.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_din"},    32'(ioctl_din),     32'hFF);
        checkOutput({tag, "_wait"},   32'(ioctl_wait),    32'h0);
        checkOutput({tag, "_req"},    32'(mem_req),       32'h0);
        checkOutput({tag, "_maddr"},  32'(mem_addr),      32'h0);
        checkOutput({tag, "_active"}, 32'(upload_active), 32'h0);
        checkOutput({tag, "_err"},    32'(err_timeout),   32'h0);
    endtask

    // One HPS read, driven and sampled on falling edges. The expected outcome
    // is derived from the ack cycle, the drop cycle and the index choice. The
    // loop then counts how many cycles the HPS was actually stalled.
    task automatic applyStimulus(input logic [15:0] addr, input int ack_at,
                                 input int drop_at, input bit wrong_index);
        logic [15:0] exp_addr;
        bit          in_range;
        bit          dropped;
        bit          acked;
        int          exp_hi;
        int          hi;
        int          glitches;
        int          k;

        exp_addr = addr + 16'(BASE);
        in_range = (32'(addr) < SIZE) && !wrong_index;
        dropped  = in_range && (drop_at > 0) && (drop_at <= TIMEOUT)
                   && ((ack_at == 0) || (drop_at <= ack_at));
        acked    = in_range && !dropped && (ack_at > 0) && (ack_at <= TIMEOUT);

        if (!in_range)    exp_hi = 0;
        else if (dropped) exp_hi = drop_at;
        else if (acked)   exp_hi = ack_at;
        else              exp_hi = TIMEOUT;

        if (wrong_index) begin
            // ignored read: byte unchanged
        end else if (!in_range) begin
            exp_din = 8'hFF;
        end else if (dropped) begin
            // aborted fetch: byte unchanged
        end else if (acked) begin
            exp_din = mem_img[exp_addr];
        end else begin
            exp_din = 8'hFF;
            exp_err = 1'b1;
        end

        if (wrong_index) ioctl_index = 8'd2;
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd   = 1'b0;
        ioctl_addr = 16'($urandom);

        hi       = 0;
        glitches = 0;
        k        = 1;
        while (ioctl_wait === 1'b1 && k <= int'(TIMEOUT) + 20) begin
            hi++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr) glitches++;
            if (k == ack_at) begin
                mem_ack  = 1'b1;
                mem_dout = mem_img[mem_addr];
            end
            if (k == drop_at) ioctl_upload = 1'b0;
            @(negedge clk_sys);
            mem_ack  = 1'b0;
            mem_dout = 8'($urandom);
            k++;
        end

        checkOutput("stall_cycles", 32'(hi), 32'(exp_hi));
        checkOutput("req_addr_hold", 32'(glitches), 32'h0);
        checkOutput("req_after", 32'(mem_req), 32'h0);
        checkOutput("din", 32'(ioctl_din), 32'(exp_din));
        checkOutput("err", 32'(err_timeout), 32'(exp_err));

        if (wrong_index) begin
            checkOutput("active_wrong_index", 32'(upload_active), 32'h0);
            ioctl_index = 8'd1;
            @(negedge clk_sys);
            @(negedge clk_sys);
            exp_err = 1'b0;
        end

        if (dropped) begin
            mem_ack  = 1'b1;
            mem_dout = ~exp_din;
            @(negedge clk_sys);
            mem_ack = 1'b0;
            checkOutput("late_ack_din", 32'(ioctl_din), 32'(exp_din));
            checkOutput("late_ack_req", 32'(mem_req), 32'h0);
            checkOutput("active_dropped", 32'(upload_active), 32'h0);
            ioctl_upload = 1'b1;
            @(negedge clk_sys);
            @(negedge clk_sys);
            exp_err = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem_img[i] = 8'($urandom);

        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd1;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 16'h0;
        mem_ack      = 1'b0;
        mem_dout     = 8'h00;
        exp_din      = 8'hFF;
        exp_err      = 1'b0;

        repeat (3) @(negedge clk_sys);
        checkResetValues("reset");
        reset = 1'b0;

        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        checkOutput("active_rise", 32'(upload_active), 32'h1);
        @(negedge clk_sys);

        // basic fetch, ack on the third FETCH cycle
        applyStimulus(16'h0010, 3, 0, 1'b0);
        // first address past the image and the very last address
        applyStimulus(16'h8000, 0, 0, 1'b0);
        applyStimulus(16'hFFFF, 0, 0, 1'b0);
        // base offset wraps: 0x2000 + 0xF000 -> 0x1000
        applyStimulus(16'h2000, 1, 0, 1'b0);
        // arbiter never answers
        applyStimulus(16'h0100, 0, 0, 1'b0);
        // a new session clears the sticky timeout flag
        ioctl_upload = 1'b0;
        repeat (2) @(negedge clk_sys);
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        exp_err = 1'b0;
        checkOutput("err_cleared", 32'(err_timeout), 32'h0);
        // session dropped mid-fetch, late ack ignored
        applyStimulus(16'h0200, 5, 2, 1'b0);
        // wrong index: no response at all
        applyStimulus(16'h0030, 1, 0, 1'b1);
        // last in-range address with minimum latency
        applyStimulus(16'h7FFF, 1, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            int          ack;
            int          drop;
            bit          wi;
            a    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(32'h8000, 32'hFFFF))
                                               : 16'($urandom_range(0, 32'h7FFF));
            ack  = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 8));
            drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 0;
            wi   = ($urandom_range(0, 7) == 0);
            applyStimulus(a, ack, drop, wi);
        end

        // reset while a fetch is outstanding
        ioctl_addr = 16'h0040;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        checkOutput("fetch_before_reset", 32'(ioctl_wait), 32'h1);
        reset = 1'b1;
        @(negedge clk_sys);
        checkResetValues("mid_fetch_reset");
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        exp_din = 8'hFF;
        exp_err = 1'b0;
        applyStimulus(16'h0041, 2, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
